updown_count_tracker: RTL and testbench
=======================================

// Module: updown_count_tracker
// PURPOSE
// - Receive-side checker for the N-bit up/down counter output bus: samples the count q and mode s each clc edge.
// - Predicts the next legal value and flags mismatches, wrap events and loss of lock.
// - Sits beside the counter in the same clc domain; feeds a status/debug register bank.
// PARAMETERS
// - N          4  width of the tracked count bus
// - MISS_LIMIT 3  consecutive mismatches that force loss of lock (1..15)
// - ERR_W      8  width of the saturating error counter
// PORTS
// - clc      in   1      system clock; all logic on posedge clc
// - rst      in   1      synchronous, active-high reset
// - s        in   1      counter mode seen by the counter: 0 = count up, 1 = count down
// - q_in     in   N      count value driven by the counter
// - locked   out  1      tracker synchronised to the count stream
// - err      out  1      one-cycle pulse: sampled q_in differs from the prediction (TRACK only)
// - wrap_up  out  1      one-cycle pulse: legal step 2^N-1 -> 0 in up mode
// - wrap_dn  out  1      one-cycle pulse: legal step 0 -> 2^N-1 in down mode
// - fault    out  1      sticky; set when lock is lost; cleared only by rst
// - err_cnt  out  ERR_W  total mismatches, saturating at 2^ERR_W-1
// BEHAVIOUR
// - Reset (rst=1 at posedge clc): state=SYNC; all outputs 0; q_prev=0; s_prev=0; miss=0. Overrides everything, including mid-TRACK.
// - All outputs are registered; each reflects the comparison made at the same clc edge.
// - SYNC: next edge with rst=0 -> q_prev<=q_in, s_prev<=s, miss<=0, locked<=1, state->TRACK. No err or wrap in SYNC.
// - TRACK, prediction: exp = q_prev+1 if s_prev=0, else q_prev-1; modulo 2^N (natural N-bit wrap).
// - Mode changes take effect one cycle later: the sample is compared using the s registered at the previous edge.
// - TRACK match (q_in==exp):
//   - err=0, miss<=0.
//   - wrap_up=1 if s_prev=0 and q_prev=2^N-1.
//   - wrap_dn=1 if s_prev=1 and q_prev=0.
// - TRACK mismatch:
//   - err=1; err_cnt+1 (saturating); miss+1.
//   - If miss+1==MISS_LIMIT: locked<=0, fault<=1, miss<=0, state->SYNC.
//   - Otherwise stay in TRACK.
// - q_prev<=q_in and s_prev<=s on every TRACK edge, match or not: the tracker re-anchors to the latest sample.
// - Simultaneous wrap and mismatch is impossible: wrap pulses only on a match.
// - err_cnt at max: stays at max; err still pulses.
// - Re-lock after a fault: the next SYNC edge sets locked=1; fault stays 1.
// CONFIGURATION
// - Macro UDC_TRACK_HOLD_EN.
// - Defined: in TRACK, q_in==q_prev also counts as a match (counter stalled/enabled-off). No err, no wrap, miss<=0.
// - Undefined: a repeated value is a mismatch like any other.
// TESTING
// - Run the bench with N=4, MISS_LIMIT=3, ERR_W=8, macro undefined unless stated.
// 1. rst=1 for 10 cycles, then q_in 0,1,2,..., s=0 -> locked=1 one edge after release; err stays 0; err_cnt=0.
// 2. Up count, q_in 14,15,0,1 -> wrap_up=1 for exactly one cycle, at the edge sampling 0; wrap_dn stays 0.
// 3. s=1, q_in 2,1,0,15,14 -> wrap_dn one-cycle pulse at the edge sampling 15; no err.
//    Then switch s 1->0 at q_in=14: q_in 13 is still expected; q_in 14 follows and must be matched next.
// 4. Up stream 4,5,9,10,11 -> err pulse only at 9; err_cnt=1; locked stays 1.
//    Three consecutive bad samples -> locked=0, fault=1 at the third; next edge locked=1; fault stays 1.
// 5. rst=1 for one edge mid-TRACK (q_in=7) -> at that edge all outputs 0, including fault and err_cnt.
//    Next edge re-syncs and sets locked=1.
// 6. Stream 3,4,4,5: macro undefined -> err at the second 4; macro UDC_TRACK_HOLD_EN defined -> no err.

Source files
------------

// File: rtl/updown_count_tracker.sv
// Receive-side checker for an N-bit up/down counter bus: predicts each next count,
// flags mismatches and wraps, and drops lock after MISS_LIMIT consecutive misses.
// Optional macro UDC_TRACK_HOLD_EN: a repeated sample (stalled counter) counts as a match.
module updown_count_tracker #(
    parameter int N          = 4,
    parameter int MISS_LIMIT = 3,
    parameter int ERR_W      = 8
) (
    input  logic             clc,
    input  logic             rst,
    input  logic             s,
    input  logic [N-1:0]     q_in,
    output logic             locked,
    output logic             err,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [3:0]       MISS_LIMIT_W = 4'(MISS_LIMIT);
    localparam logic [ERR_W-1:0] ERR_MAX      = '1;
    localparam logic [N-1:0]     Q_MAX        = '1;

    state_t           state_q, state_d;
    logic [N-1:0]     q_prev_q, q_prev_d;
    logic             s_prev_q, s_prev_d;
    logic [3:0]       miss_q, miss_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             wrap_up_q, wrap_up_d;
    logic             wrap_dn_q, wrap_dn_d;
    logic             fault_q, fault_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [N-1:0]     exp_val;
    logic [3:0]       miss_inc;

    // Prediction uses the mode registered at the previous edge, so mode changes lag one cycle.
    assign exp_val  = s_prev_q ? (q_prev_q - 1'b1) : (q_prev_q + 1'b1);
    assign miss_inc = miss_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        q_prev_d  = q_prev_q;
        s_prev_d  = s_prev_q;
        miss_d    = miss_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        wrap_up_d = 1'b0;
        wrap_dn_d = 1'b0;
        fault_d   = fault_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            SYNC: begin
                q_prev_d = q_in;
                s_prev_d = s;
                miss_d   = '0;
                locked_d = 1'b1;
                state_d  = TRACK;
            end
            TRACK: begin
                q_prev_d = q_in;
                s_prev_d = s;
`ifdef UDC_TRACK_HOLD_EN
                if (q_in == q_prev_q) begin
                    miss_d = '0;
                end else
`endif
                if (q_in == exp_val) begin
                    miss_d    = '0;
                    wrap_up_d = !s_prev_q && (q_prev_q == Q_MAX);
                    wrap_dn_d = s_prev_q && (q_prev_q == '0);
                end else begin
                    err_d = 1'b1;
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    // Too many consecutive misses: give up and re-anchor on the next sample.
                    if (miss_inc == MISS_LIMIT_W) begin
                        locked_d = 1'b0;
                        fault_d  = 1'b1;
                        miss_d   = '0;
                        state_d  = SYNC;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge clc) begin
        if (rst) begin
            state_q   <= SYNC;
            q_prev_q  <= '0;
            s_prev_q  <= 1'b0;
            miss_q    <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            wrap_up_q <= 1'b0;
            wrap_dn_q <= 1'b0;
            fault_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            q_prev_q  <= q_prev_d;
            s_prev_q  <= s_prev_d;
            miss_q    <= miss_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            wrap_up_q <= wrap_up_d;
            wrap_dn_q <= wrap_dn_d;
            fault_q   <= fault_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign wrap_up = wrap_up_q;
    assign wrap_dn = wrap_dn_q;
    assign fault   = fault_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_updown_count_tracker.sv
// Directed bench for updown_count_tracker (N=4, MISS_LIMIT=3, ERR_W=8); expectations
// follow UDC_TRACK_HOLD_EN when the bench is compiled with that macro.
module tb_updown_count_tracker;

    logic       clc;
    logic       rst;
    logic       s;
    logic [3:0] q_in;
    logic       locked;
    logic       err;
    logic       wrap_up;
    logic       wrap_dn;
    logic       fault;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    updown_count_tracker #(
        .N         (4),
        .MISS_LIMIT(3),
        .ERR_W     (8)
    ) dut (
        .clc    (clc),
        .rst    (rst),
        .s      (s),
        .q_in   (q_in),
        .locked (locked),
        .err    (err),
        .wrap_up(wrap_up),
        .wrap_dn(wrap_dn),
        .fault  (fault),
        .err_cnt(err_cnt)
    );

    initial clc = 1'b0;
    always #5 clc = ~clc;

    // Drive one sample, let it be taken at the next rising edge, then settle 1 time unit.
    task automatic applyStimulus(input logic r, input logic mode, input logic [3:0] q);
        rst  = r;
        s    = mode;
        q_in = q;
        @(posedge clc);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst  = 1'b1;
        s    = 1'b0;
        q_in = 4'd0;

        // Reset held for ten edges.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("rst_locked",  32'(locked),  32'd0);
        checkOutput("rst_err",     32'(err),     32'd0);
        checkOutput("rst_fault",   32'(fault),   32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_wraps",   32'({wrap_up, wrap_dn}), 32'd0);

        // Lock one edge after release, then a clean up count.
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("sync_locked", 32'(locked), 32'd1);
        checkOutput("sync_err",    32'(err),    32'd0);
        for (int v = 1; v <= 13; v++) begin
            applyStimulus(1'b0, 1'b0, 4'(v));
            checkOutput($sformatf("up_err_%0d", v),  32'(err),     32'd0);
            checkOutput($sformatf("up_wrap_%0d", v), 32'(wrap_up), 32'd0);
        end
        checkOutput("up_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("up_locked",  32'(locked),  32'd1);

        // Up wrap 14,15,0,1.
        applyStimulus(1'b0, 1'b0, 4'd14);
        checkOutput("wu14_wrap_up", 32'(wrap_up), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd15);
        checkOutput("wu15_wrap_up", 32'(wrap_up), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("wu0_wrap_up",  32'(wrap_up), 32'd1);
        checkOutput("wu0_wrap_dn",  32'(wrap_dn), 32'd0);
        checkOutput("wu0_err",      32'(err),     32'd0);
        applyStimulus(1'b0, 1'b0, 4'd1);
        checkOutput("wu1_wrap_up",  32'(wrap_up), 32'd0);

        // Down count 2,1,0,15,14: mode sampled with 2 only takes effect for the following sample.
        applyStimulus(1'b0, 1'b1, 4'd2);
        checkOutput("dn2_err", 32'(err), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'd1);
        checkOutput("dn1_err", 32'(err), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'd0);
        checkOutput("dn0_err",     32'(err),     32'd0);
        checkOutput("dn0_wrap_dn", 32'(wrap_dn), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'd15);
        checkOutput("dn15_wrap_dn", 32'(wrap_dn), 32'd1);
        checkOutput("dn15_wrap_up", 32'(wrap_up), 32'd0);
        checkOutput("dn15_err",     32'(err),     32'd0);
        applyStimulus(1'b0, 1'b1, 4'd14);
        checkOutput("dn14_wrap_dn", 32'(wrap_dn), 32'd0);
        checkOutput("dn14_err",     32'(err),     32'd0);

        // Mode switches to up while the counter still produced 13; 14 and 15 follow.
        applyStimulus(1'b0, 1'b0, 4'd13);
        checkOutput("sw13_err", 32'(err), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd14);
        checkOutput("sw14_err", 32'(err), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd15);
        checkOutput("sw15_err", 32'(err), 32'd0);
        checkOutput("sw_err_cnt", 32'(err_cnt), 32'd0);

        // Up stream 0..5, then a jump to 9, then 10, 11.
        for (int v = 0; v <= 5; v++) begin
            applyStimulus(1'b0, 1'b0, 4'(v));
            checkOutput($sformatf("pre_err_%0d", v), 32'(err), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 4'd9);
        checkOutput("j9_err",     32'(err),     32'd1);
        checkOutput("j9_err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("j9_locked",  32'(locked),  32'd1);
        checkOutput("j9_wraps",   32'({wrap_up, wrap_dn}), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd10);
        checkOutput("j10_err", 32'(err), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd11);
        checkOutput("j11_err",     32'(err),     32'd0);
        checkOutput("j11_err_cnt", 32'(err_cnt), 32'd1);

        // Three consecutive bad samples lose lock.
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("bad1_err",     32'(err),     32'd1);
        checkOutput("bad1_err_cnt", 32'(err_cnt), 32'd2);
        checkOutput("bad1_locked",  32'(locked),  32'd1);
        applyStimulus(1'b0, 1'b0, 4'd7);
        checkOutput("bad2_err_cnt", 32'(err_cnt), 32'd3);
        checkOutput("bad2_locked",  32'(locked),  32'd1);
        checkOutput("bad2_fault",   32'(fault),   32'd0);
        applyStimulus(1'b0, 1'b0, 4'd3);
        checkOutput("bad3_err",     32'(err),     32'd1);
        checkOutput("bad3_err_cnt", 32'(err_cnt), 32'd4);
        checkOutput("bad3_locked",  32'(locked),  32'd0);
        checkOutput("bad3_fault",   32'(fault),   32'd1);
        applyStimulus(1'b0, 1'b0, 4'd4);
        checkOutput("relock_locked",  32'(locked),  32'd1);
        checkOutput("relock_fault",   32'(fault),   32'd1);
        checkOutput("relock_err",     32'(err),     32'd0);
        checkOutput("relock_err_cnt", 32'(err_cnt), 32'd4);
        applyStimulus(1'b0, 1'b0, 4'd5);
        checkOutput("relock5_err", 32'(err), 32'd0);

        // Reset for a single edge mid-TRACK clears everything.
        applyStimulus(1'b0, 1'b0, 4'd6);
        applyStimulus(1'b1, 1'b0, 4'd7);
        checkOutput("mid_rst_locked",  32'(locked),  32'd0);
        checkOutput("mid_rst_fault",   32'(fault),   32'd0);
        checkOutput("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("mid_rst_err",     32'(err),     32'd0);
        applyStimulus(1'b0, 1'b0, 4'd8);
        checkOutput("mid_resync_locked", 32'(locked), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'd9);
        checkOutput("mid_resync_err", 32'(err), 32'd0);

        // Repeated value: 3,4,4,5 after a fresh reset.
        applyStimulus(1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd3);
        checkOutput("hold3_locked", 32'(locked), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'd4);
        checkOutput("hold4a_err", 32'(err), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd4);
`ifdef UDC_TRACK_HOLD_EN
        checkOutput("hold4b_err",     32'(err),     32'd0);
        checkOutput("hold4b_err_cnt", 32'(err_cnt), 32'd0);
`else
        checkOutput("hold4b_err",     32'(err),     32'd1);
        checkOutput("hold4b_err_cnt", 32'(err_cnt), 32'd1);
`endif
        applyStimulus(1'b0, 1'b0, 4'd5);
        checkOutput("hold5_err",    32'(err),    32'd0);
        checkOutput("hold5_locked", 32'(locked), 32'd1);

        // Saturation: alternating 0/8 gives three misses then a SYNC edge, every four edges.
        for (int i = 1; i <= 400; i++) begin
            applyStimulus(1'b0, 1'b0, (i % 2 == 1) ? 4'd0 : 4'd8);
        end
        checkOutput("sat_err_cnt", 32'(err_cnt), 32'd255);
        checkOutput("sat_locked",  32'(locked),  32'd1);
        checkOutput("sat_err_sync_edge", 32'(err), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd3);
        checkOutput("sat_err_pulse",  32'(err),     32'd1);
        checkOutput("sat_err_cnt_hold", 32'(err_cnt), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
